mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning the RAM word width.
REQ-002 The module SHALL have parameter RAM_SIZE, default 256, meaning the number of RAM words.
REQ-003 The module SHALL have parameter ADDR_W, default $clog2(RAM_SIZE), meaning the address width.
REQ-004 The module SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-005 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The module SHALL have ports req0/req1  input  1  access request, port 0 / port 1.
REQ-007 The module SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-008 The module SHALL have ports lock0/lock1  input  1  keep ownership after this access (read-modify-write).
REQ-009 The module SHALL have ports addr0/addr1  input  ADDR_W  word address.
REQ-010 The module SHALL have ports wdata0/wdata1  input  DATA_W  write data.
REQ-011 The module SHALL have ports gnt0/gnt1  output  1  access accepted this cycle (combinational).
REQ-012 The module SHALL have ports rvalid0/rvalid1  output  1  read data valid on rdata0/rdata1.
REQ-013 The module SHALL have ports rdata0/rdata1  output  DATA_W  read data.
REQ-014 The module SHALL have port ram_raddr  output  ADDR_W  RAM read address.
REQ-015 The module SHALL have port ram_dout  input  DATA_W  RAM registered read data (1-cycle latency).
REQ-016 The module SHALL have ports ram_we / ram_waddr / ram_din  output  1 / ADDR_W / DATA_W  RAM write strobe, write address and write data.

Function
REQ-017 At most one of gnt0/gnt1 SHALL be high in any cycle; a grant SHALL be issued only to a requester with reqN=1.
REQ-018 A requester SHALL hold req, we, lock, addr and wdata stable until gnt; the access takes effect in the cycle gnt is high.
REQ-019 Write grant: ram_we=1, ram_waddr=addrN, ram_din=wdataN in the same cycle; the RAM is written at that clock edge.
REQ-020 Read grant: ram_raddr=addrN in the grant cycle; rvalidN SHALL be 1 exactly the next cycle, with rdataN=ram_dout.
REQ-021 With no grant: ram_we=0, ram_raddr=0, ram_waddr=0, ram_din=0.
REQ-022 rdata0/rdata1 SHALL be 0 while the corresponding rvalid is 0.
REQ-023 The FSM SHALL have states FREE, OWN0 and OWN1.
REQ-024 FREE, single request: that port SHALL be granted.
REQ-025 FREE, both requests: the port not granted most recently SHALL win; the last-served pointer updates on every grant.
REQ-026 FREE: granting port N with lockN=1 SHALL move the FSM to OWNN.
REQ-027 OWNN: only port N SHALL be granted; the other port waits regardless of priority.
REQ-028 OWNN SHALL return to FREE when port N is granted with lockN=0, or when reqN=0 and lockN=0.
REQ-029 OWNN with reqN=0 and lockN=1: no grant and the state SHALL be held.
REQ-030 Back-to-back grants SHALL be supported: a read-then-write to the same address in consecutive cycles returns the pre-write value.

Reset
REQ-031 While rst_n=0: state=FREE; last-served=port 1, so port 0 wins the first tie; rvalid0=rvalid1=0; rdata0=rdata1=0; gnt0=gnt1=0; ram_we=0.
REQ-032 Reset mid-read SHALL drop the pending rvalid; no rvalid SHALL be issued after reset release for a pre-reset grant.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (FREE=2'd0, OWN0=2'd1, OWN1=2'd2) and the default widths DATA_W and RAM_SIZE.
REQ-034 The grant logic SHALL be one natural sub-module, rr_arb2: a 2-way round-robin with a mask input for the OWN states.
REQ-035 The RAM SHALL be instantiated outside this module, with its read and write clocks both tied to clk.

Verification
REQ-036 The bench SHALL cover: after reset, req0=req1=1, we=0, addr0=3, addr1=5, over 2 cycles -> gnt0 then gnt1; rvalid0 one cycle after gnt0 with mem[3]; rvalid1 one cycle after gnt1 with mem[5].
REQ-037 The bench SHALL cover: req0 write addr 7 data 8'hA5 granted, then req1 read addr 7 next cycle -> rdata1=8'hA5 one cycle later.
REQ-038 The bench SHALL cover: port0 read addr 2 with lock0=1 while req1 is held -> gnt1=0 through port0's read and its write of addr 2 with lock0=0; gnt1 the following cycle.
REQ-039 The bench SHALL cover: OWN1 with req1=0 and lock1=1 for 4 cycles while req0=1 -> no gnt0 and state held; lock1 deasserted -> gnt0 the next cycle.
REQ-040 The bench SHALL cover: rst_n asserted low in the cycle after a read grant -> rvalid stays 0; after release the first tie goes to port 0.
REQ-041 The bench SHALL cover: 1000 cycles of random req/we/lock with a reference model -> read data matches, gnt is never on both ports, and no port is starved while the other is unlocked.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   - state_t   : ownership FSM encoding (FREE / OWN0 / OWN1)
//   - DATA_W    : default RAM word width
//   - RAM_SIZE  : default number of RAM words
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int DATA_W   = 8;
  localparam int RAM_SIZE = 256;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a per-port enable mask.
// A port competes only when both its req and mask bits are set. On a tie the
// port that was not granted most recently wins. The last-served pointer moves
// on every grant and resets to port 1, so port 0 wins the first tie.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req  [1:0]  : raw requests, bit N = port N
//   mask [1:0]  : eligibility, bit N = port N may be granted this cycle
//   gnt  [1:0]  : one-hot (or zero) grant, combinational
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic       last;   // 1'b0 = port 0 served last, 1'b1 = port 1 served last
  logic [1:0] elig;

  assign elig = req & mask;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    unique case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (gnt[0]) begin
      last <= 1'b0;
    end else if (gnt[1]) begin
      last <= 1'b1;
    end
  end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one external simple-dual-port RAM (registered read, 1-cycle latency)
// between two requesters. A requester holds its request until gnt; the
// access happens in the grant cycle. lockN keeps ownership across accesses
// so a read-modify-write sequence cannot be interleaved by the other port.
//
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req0/1, we0/1, lock0/1      : request, write(1)/read(0), keep ownership
//   addr0/1, wdata0/1           : word address, write data
//   gnt0/1                      : access accepted this cycle (combinational)
//   rvalid0/1, rdata0/1         : read data, one cycle after a read grant
//   ram_raddr, ram_dout         : RAM read address / registered read data
//   ram_we, ram_waddr, ram_din  : RAM write strobe, address, data
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_W   = mem_arbiter_pkg::DATA_W,
  parameter int RAM_SIZE = mem_arbiter_pkg::RAM_SIZE,
  parameter int ADDR_W   = $clog2(RAM_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_din
);

  import mem_arbiter_pkg::*;

  state_t     state, state_next;
  logic [1:0] own_mask;
  logic [1:0] mask;
  logic [1:0] gnt;

  // ---------------------------------------------------------------------------
  // Ownership FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FREE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    own_mask   = 2'b11;
    unique case (state)
      FREE: begin
        if (gnt0 && lock0) begin
          state_next = OWN0;
        end else if (gnt1 && lock1) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        own_mask = 2'b01;
        // Owner releases by a final unlocked access or by idling unlocked;
        // idling with lock held keeps the other port waiting.
        if (!lock0 && (gnt0 || !req0)) begin
          state_next = FREE;
        end
      end
      OWN1: begin
        own_mask = 2'b10;
        if (!lock1 && (gnt1 || !req1)) begin
          state_next = FREE;
        end
      end
      default: begin
        state_next = FREE;
      end
    endcase
  end

  // Grants are combinational from req, so they are forced off while reset is
  // asserted even if requesters are already driving req.
  assign mask = rst_n ? own_mask : 2'b00;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({req1, req0}),
    .mask (mask),
    .gnt  (gnt)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // ---------------------------------------------------------------------------
  // RAM port steering; everything is zero when nothing is granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_din   = '0;
    ram_raddr = '0;
    if (gnt0) begin
      if (we0) begin
        ram_we    = 1'b1;
        ram_waddr = addr0;
        ram_din   = wdata0;
      end else begin
        ram_raddr = addr0;
      end
    end else if (gnt1) begin
      if (we1) begin
        ram_we    = 1'b1;
        ram_waddr = addr1;
        ram_din   = wdata1;
      end else begin
        ram_raddr = addr1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: the RAM output register already provides the one-cycle
  // latency, so only the valid flag is tracked here. Reset clears it, which
  // drops any read granted just before reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
    end
  end

  assign rdata0 = rvalid0 ? ram_dout : '0;
  assign rdata1 = rvalid1 ? ram_dout : '0;

endmodule : mem_arbiter
